// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: 4x4 active-low keypad scan, frame debounce and
// press-event generation into a 16-bit bitmap (bit 15 = top-left cell).
//
// Ports:
//   system_clk  rising-edge clock
//   rst         synchronous active-high reset
//   col_in      column lines, active-low, col_in[3] = leftmost column
//   row_out     one-hot active-low row drive, row_out[0] = top row
//   key_state   debounced pressed map, 1 = pressed
//   key_valid   one-cycle pulse on a commit that contains a new press
//   key_code    lowest bit index of the newly pressed keys (held)
module keypad_matrix_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        system_clk,
    input  logic        rst,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [15:0] key_state,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DB_MAX     = 4'(DEBOUNCE_SCANS);

    logic [3:0]  col_meta;
    logic [3:0]  col_sync;
    logic [1:0]  row_idx;
    logic [15:0] dwell;
    logic [15:0] raw_frame;
    logic [15:0] prev_frame;
    logic [3:0]  stable_cnt;
    logic        frame_done;

    logic        sample;
    logic [3:0]  cols_pressed;
    logic [15:0] frame_full;
    logic [3:0]  stable_next;
    logic [15:0] new_keys;
    logic [3:0]  new_code;
    logic        commit;

    assign sample       = (dwell == DWELL_LAST);
    assign cols_pressed = ~col_sync;

    // Completed frame as seen at the row-3 sample: rows 0..2 come from
    // the raw frame register, row 3 from the columns being sampled now.
    always_comb begin
        frame_full      = raw_frame;
        frame_full[3:0] = cols_pressed;
    end

    always_comb begin
        stable_next = 4'd1;
        if (frame_full == prev_frame) begin
            if (stable_cnt < DB_MAX) begin
                stable_next = stable_cnt + 4'd1;
            end else begin
                stable_next = DB_MAX;
            end
        end
    end

    // The commit runs one cycle after frame end; by then prev_frame holds
    // the completed frame and stable_cnt holds its updated count.
    assign commit   = frame_done && (stable_cnt == DB_MAX) &&
                      (prev_frame != key_state);
    assign new_keys = prev_frame & ~key_state;

    // Lowest set bit wins: later loop iterations overwrite earlier ones.
    always_comb begin
        new_code = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (new_keys[i]) begin
                new_code = 4'(i);
            end
        end
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            col_meta   <= 4'b1111;
            col_sync   <= 4'b1111;
            row_idx    <= 2'd0;
            dwell      <= 16'd0;
            row_out    <= 4'b1110;
            raw_frame  <= 16'h0000;
            prev_frame <= 16'h0000;
            stable_cnt <= DB_MAX;
            frame_done <= 1'b0;
            key_state  <= 16'h0000;
            key_valid  <= 1'b0;
            key_code   <= 4'h0;
        end else begin
            col_meta   <= col_in;
            col_sync   <= col_meta;
            frame_done <= 1'b0;
            key_valid  <= 1'b0;

            if (sample) begin
                dwell   <= 16'd0;
                row_idx <= row_idx + 2'd1;
                row_out <= ~(4'b0001 << (row_idx + 2'd1));
                // Row r lands in bits [15-4r : 12-4r], column 0 at MSB.
                raw_frame[{~row_idx, 2'b00} +: 4] <= cols_pressed;
                if (row_idx == 2'd3) begin
                    prev_frame <= frame_full;
                    stable_cnt <= stable_next;
                    frame_done <= 1'b1;
                end
            end else begin
                dwell <= dwell + 16'd1;
            end

            if (commit) begin
                key_state <= prev_frame;
                if (|new_keys) begin
                    key_valid <= 1'b1;
                    key_code  <= new_code;
                end
            end
        end
    end

endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Scans a 4x4 active-low keypad matrix and debounces it into a 16-bit key bitmap. The bitmap uses the same cell ordering as the 16-bit framebuffer fed to the LED matrix driver: bit 15 is the top-left cell and bit 0 is the bottom-right. The block is the input-side counterpart of the display scan. It drives one keypad row at a time, samples the columns, and reports stable key state plus single-cycle press events to the game logic.

## Interface
- SCAN_DIV, default 1000: system_clk cycles each row is driven; legal range 4..65535.
- DEBOUNCE_SCANS, default 4: number of consecutive identical full-frame scans required before the bitmap commits; legal range 1..15.
- system_clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset rst, synchronous, active-high.
- col_in  input  4  keypad column lines; asynchronous, active-low, pulled high externally; col_in[3] is the leftmost column.
- row_out  output  4  keypad row drive; one-hot active-low; row_out[0] is the top row.
- key_state  output  16  debounced pressed map, 1 = pressed; bit index = 15 - (4*r + c), with r = row 0..3 from the top and c = column 0..3 from the left.
- key_valid  output  1  one-cycle pulse when a committed update contains at least one newly pressed key.
- key_code  output  4  bit index of the lowest-indexed newly pressed key; valid when key_valid is high, holds its value otherwise.

## Operation
- Synchronizer:
  - col_in passes through 2 flops; both reset to 4'b1111.
  - The synchronized value is inverted, so 1 = pressed.
- Scan:
  - row index r (2 bits) and dwell counter d (16 bits) reset to 0.
  - row_out = ~(4'b0001 << r).
  - d counts 0..SCAN_DIV-1.
  - When d = SCAN_DIV-1:
    - sample the synchronized, inverted columns into raw-frame bits [15-4r : 12-4r], with column 0 at the MSB;
    - set d to 0;
    - set r to r+1, wrapping 3 -> 0.
- Frame end is the sample taken when r = 3. At frame end the completed raw frame F is compared with the previous frame P:
  - F == P: stable_cnt = min(stable_cnt+1, DEBOUNCE_SCANS).
  - F != P: stable_cnt = 1.
  - In both cases P <= F.
- Commit:
  - Condition: frame end, the updated stable_cnt equals DEBOUNCE_SCANS, and F != key_state.
  - Action: key_state <= F.
  - new = F & ~key_state_old.
  - If new != 0: key_valid = 1 for one cycle and key_code = index of the lowest set bit of new.
  - Releases update key_state only and never pulse key_valid.
- Several keys newly pressed in the same commit produce one pulse, reporting the lowest index. The other keys are visible only through key_state.
- DEBOUNCE_SCANS = 1 commits every frame that differs from key_state.
- Ghosting from 3+ simultaneous keys is not masked; the bitmap reports what is sampled.
- rst at any cycle, including mid-frame:
  - all state returns to its reset value on the next edge;
  - a partially assembled frame is discarded;
  - no key_valid pulse is produced.

## Timing
- Reset values:
  - row_out = 4'b1110; key_state = 16'h0000; key_valid = 0; key_code = 4'h0.
  - r = 0; d = 0; P = 16'h0000; stable_cnt = DEBOUNCE_SCANS; raw frame = 16'h0000.
- Row r is driven for exactly SCAN_DIV cycles; one full frame is 4*SCAN_DIV cycles.
- The row_out change is registered and appears on the edge after the row-3 sample.
- Sampling at d = SCAN_DIV-1 gives SCAN_DIV-3 cycles of settling after the 2-flop synchronizer; hence SCAN_DIV >= 4.
- key_state and key_valid/key_code update on the edge following the row-3 sample edge. That is 1 cycle after frame end, and registered outputs only.
- Press latency from the first frame fully containing a stable press: DEBOUNCE_SCANS frames, plus 1 cycle.
- Consecutive key_valid pulses are separated by at least 4*SCAN_DIV cycles.

## Test plan
Parameters for all scenarios: SCAN_DIV = 4, DEBOUNCE_SCANS = 2.
- Reset, idle columns 4'b1111 for 64 cycles:
  - row_out cycles 1110, 1101, 1011, 0111, changing every 4 cycles;
  - key_state stays 0; key_valid never asserts.
- Hold the key at row 1, col 2 (col_in = 4'b1101 while row_out = 4'b1101) from a frame boundary:
  - key_state = 16'h0200 and key_valid pulses with key_code = 9, one cycle after the 2nd frame end;
  - no further pulses while the key is held.
- Release that key:
  - key_state returns to 0 after 2 frames; no key_valid pulse.
- Press row 0 col 0 and row 3 col 3 together:
  - key_state = 16'h8001; a single key_valid pulse with key_code = 0.
- Bounce: toggle a key every other frame for 8 frames, then hold it:
  - key_state unchanged during the toggling;
  - commit occurs exactly 2 frames after the hold begins.
- Assert rst for 1 cycle in the middle of row 2 while a key is held:
  - all outputs return to reset values;
  - scan restarts at row 0;
  - the key re-commits 2 full frames later with one fresh key_valid pulse.
